// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and frame widths.
// Used by uart_rx today; uart_tx will pick up the same constants.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 100;
    localparam int DATA_BITS            = 8;
    localparam int BIT_IDX_W            = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with a configurable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with parity checking.
// Delivers each byte as a one-cycle valid strobe with coincident frame/parity error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HALF_C = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_e          state;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;
    logic                 mismatch;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    // Even parity: XOR over data and parity bit must be 0.
    assign mismatch = ^{shreg, par_bit};

    always_ff @(posedge clk) begin
        if (rst)
            par_bit <= 1'b0;
        else if (state == PARITY && cnt == LAST_C)
            par_bit <= rx_s;
    end
`else
    assign mismatch = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s)
                        state <= START;
                end
                START: begin
                    if (cnt == HALF_C) begin
                        // Line back high at mid start bit means it was a glitch.
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == LAST_C) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + BIT_IDX_W'(1);
                        if (bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == LAST_C) begin
                        cnt   <= '0;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt == LAST_C) begin
                        cnt        <= '0;
                        data       <= shreg;
                        valid      <= 1'b1;
                        frame_err  <= ~rx_s;
                        parity_err <= mismatch;
                        // Leaving mid stop bit leaves half a bit to catch a back-to-back start.
                        state      <= rx_s ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BREAK: begin
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random byte streams against a frame-level model.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NBITS = PAR ? 11 : 10;
    localparam int FR    = NBITS * CPB;
    localparam int LAT   = 3 + HALF + (NBITS - 1) * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, parity_err, busy;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int busy_cycles = 0;
    int last_t0 = 0;

    logic [9:0] ev_q[$];
    int         ev_t[$];
    logic [9:0] exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle with valid high is logged as one delivered frame.
    always @(negedge clk) begin
        if (valid) begin
            ev_q.push_back({parity_err, frame_err, data});
            ev_t.push_back(cyc);
        end
        if (busy) busy_cycles <= busy_cycles + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic align;
        @(posedge clk);
        #1;
    endtask

    // Model: a frame of byte b is start, 8 data LSB first, [even parity ^ flip], stop.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic flip);
        last_t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR) drive_bit((^b) ^ flip);
        drive_bit(stop_bit);
        exp_q.push_back({PAR & flip, ~stop_bit, b});
    endtask

    task automatic idle_wait(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_events(input string tag);
        check({tag, ".count"}, ev_q.size(), exp_q.size());
        while (ev_q.size() > 0 && exp_q.size() > 0)
            check({tag, ".frame"}, ev_q.pop_front(), exp_q.pop_front());
        ev_q.delete();
        ev_t.delete();
        exp_q.delete();
    endtask

    initial begin
        int t_a, t_b, dt;
        logic [7:0] b;
        logic s, f;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.data", data, 8'h00);
        check("rst.valid", valid, 1'b0);
        check("rst.frame_err", frame_err, 1'b0);
        check("rst.parity_err", parity_err, 1'b0);
        check("rst.busy", busy, 1'b0);
        align;
        rst = 1'b0;
        idle_wait(CPB);

        // Single frame 0xA5 and its latency
        send_frame(8'hA5, 1'b1, 1'b0);
        idle_wait(2 * CPB);
        check("a5.n", ev_t.size(), 1);
        if (ev_t.size() > 0) begin
            dt = ev_t[0] - last_t0;
            check("a5.latency_ok", (dt >= LAT - 1 && dt <= LAT + 1), 1'b1);
        end
        check_events("a5");

        // Back-to-back 0x00 then 0xFF with no idle time
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle_wait(2 * CPB);
        if (ev_t.size() >= 2) begin
            t_a = ev_t[0];
            t_b = ev_t[1];
            check("b2b.spacing_ok", ((t_b - t_a) >= FR - 1 && (t_b - t_a) <= FR + 1), 1'b1);
        end
        check_events("b2b");

        // 3-cycle low glitch on an idle line
        busy_cycles = 0;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle_wait(3 * CPB);
        check("glitch.busy_short", (busy_cycles > 0 && busy_cycles <= HALF + 4), 1'b1);
        check("glitch.idle", busy, 1'b0);
        check_events("glitch");

        // Framing error followed by a long break
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        check("break.busy_low", busy, 1'b1);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("break.busy_after", busy, 1'b0);
        idle_wait(2 * FR);
        check_events("break");

        // Reset pulse in the middle of the data bits of 0x55
        align;
        b = 8'h55;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx  = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst.data", data, 8'h00);
        check("midrst.valid", valid, 1'b0);
        check("midrst.frame_err", frame_err, 1'b0);
        check("midrst.busy", busy, 1'b0);
        idle_wait(2 * FR);
        check_events("midrst");
        send_frame(8'h81, 1'b1, 1'b0);
        idle_wait(2 * CPB);
        check_events("after_rst");

`ifdef UART_RX_PARITY_EN
        // Parity: 0x07 with correct then flipped parity bit
        send_frame(8'h07, 1'b1, 1'b0);
        idle_wait(CPB);
        send_frame(8'h07, 1'b1, 1'b1);
        idle_wait(2 * CPB);
        check_events("parity");
`endif

        // Full byte sweep, back-to-back
        for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1, 1'b0);
        idle_wait(2 * CPB);
        check_events("sweep");

        // Random bytes, random gaps, occasional bad stop/parity bits
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 7) != 0);
            f = ($urandom_range(0, 3) == 0);
            send_frame(b, s, f);
            if (!s) idle_wait(CPB);
            else idle_wait($urandom_range(0, CPB));
        end
        idle_wait(2 * CPB);
        check_events("random");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver. Frame format is 8N1 by default: one start bit, 8 data bits LSB first, one stop bit.
- Receives frames sent by the SoC's uart_tx and by external hosts.
- Delivers each byte as a one-cycle valid strobe with error flags to the MMIO UART status/data register block.
- Uses the same CLKS_PER_BIT timing model as the transmitter, so one parameter value configures both ends.

Parameters:
- CLKS_PER_BIT, 100, clock cycles per serial bit; must be >= 4. Half-bit point HALF = (CLKS_PER_BIT-1)/2, integer division.
- CNT_W, 16, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- data  output  8  last received byte; holds value until the next frame completes.
- valid  output  1  one-cycle pulse; data is valid in the same cycle.
- frame_err  output  1  one-cycle pulse, coincident with valid, when the stop bit is sampled as 0.
- parity_err  output  1  one-cycle pulse, coincident with valid, on parity mismatch; tied 0 without UART_RX_PARITY_EN.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset, synchronous and active-high (clk, rst):
  - Outputs: data=0x00, valid=0, frame_err=0, parity_err=0, busy=0.
  - Internals: state=IDLE, counter=0, bit_idx=0, both synchronizer flops=1.
  - Asserting rst mid-frame aborts the frame; no valid is produced for it.
- Input path:
  - rx passes through a 2-FF synchronizer into rx_s.
  - rx_s is the only signal the FSM reads.
- IDLE:
  - busy=0. When rx_s==0, go to START with counter=0.
- START:
  - Counter increments each cycle.
  - When counter==HALF, sample rx_s.
  - If rx_s==0: go to DATA, counter=0, bit_idx=0.
  - If rx_s==1: glitch; return to IDLE with no outputs.
- DATA:
  - Counter counts 0..CLKS_PER_BIT-1.
  - At CLKS_PER_BIT-1, sample rx_s into shift register bit bit_idx (LSB first), then counter=0.
  - After bit_idx==7 is sampled, go to STOP, or to PARITY if the feature is compiled in.
- PARITY (feature only):
  - One full bit period, sampled at CLKS_PER_BIT-1.
- STOP:
  - Sample at CLKS_PER_BIT-1, which is mid stop bit.
  - On that same cycle: data<=shift register, valid<=1, frame_err<=~rx_s, parity_err<=mismatch.
  - If rx_s==1, go to IDLE, so the next start edge can be caught within half a bit.
  - If rx_s==0, go to BREAK.
- BREAK:
  - busy=1. Wait until rx_s==1, then go to IDLE.
  - Prevents a held-low line (break condition) from being decoded as repeated 0x00 frames.
- Strobe behaviour:
  - valid, frame_err and parity_err are registered pulses, exactly 1 cycle each.
  - The byte is delivered even when frame_err is set.
- Latency:
  - t0 is the cycle rx falls; the FSM sees it at t0+2 and enters START at t0+3.
  - valid is high in cycle t0 + 3 + HALF + 9*CLKS_PER_BIT + 1, with ±1 cycle bench tolerance.
  - With the parity feature, add CLKS_PER_BIT.
- Back-to-back frames: a start bit directly following the stop bit, with zero idle time, must be received with no byte loss.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds the PARITY state and a 9th bit after the data bits, using even parity.
  - parity_err = XOR(data bits, parity bit).
  - Frame becomes 8E1.
- Undefined:
  - Frame is 8N1 and the PARITY state does not exist.
  - parity_err is constant 0.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants IDLE, START, DATA, PARITY, STOP, BREAK (3-bit);
  - default CLKS_PER_BIT;
  - frame width constants.
- uart_tx is to migrate to the same package.
- Sub-module sync_2ff (generic 1-bit, reset value 1) holds the synchronizer; it is reused by the GPIO inputs.

Test Plan (CLKS_PER_BIT=16 unless noted):
- Drive byte 0xA5 as 8N1 → valid pulses once, data=0xA5, frame_err=0, parity_err=0; valid cycle within tolerance of the latency formula.
- Two bytes back-to-back, 0x00 then 0xFF, with zero idle → two valid pulses 160 cycles apart (±1), data=0x00 then 0xFF.
- Low glitch of 3 cycles on idle rx → no valid, FSM returns to IDLE, busy high for no more than HALF+4 cycles.
- Byte 0x3C with stop bit forced 0, then line held low 500 cycles, then high → exactly one valid with data=0x3C and frame_err=1, no further valid, busy=0 after rx rises.
- rst pulsed 1 cycle in the middle of the DATA phase of 0x55 → no valid, all outputs at reset values; the next clean frame 0x81 is received correctly.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 → parity_err=0; 0x07 with parity bit 0 → parity_err=1 with valid; uart_tx→uart_rx loopback at CLKS_PER_BIT=100 gives bytes 0x00..0xFF all matching.
